// File: rtl/mem_pkg.sv
// Shared memory-path definitions: lane geometry and FSM encodings for the vector
// load and store sides.
package mem_pkg;

    localparam int unsigned LANE_W = 16;
    localparam int unsigned LANES  = 3;
    localparam int unsigned VEC_W  = LANES * LANE_W;
    localparam int unsigned ADDR_W = 32;

    // Store side: serialise one vector into LANES single-lane writes
    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDone
    } store_state_e;

    // Load side: gather LANES single-lane reads into one vector
    localparam int unsigned LOAD_LANES   = LANES;
    localparam int unsigned LOAD_DATA_W  = LANE_W;
    localparam int unsigned LOAD_RESULT_W = VEC_W;

    typedef enum logic [1:0] {
        LdIdle,
        LdRead,
        LdDone
    } load_state_e;

    // Lane address, wrapping modulo 2^ADDR_W
    function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] idx,
                                                    input logic [ADDR_W-1:0] step);
        return base + idx * step;
    endfunction

endpackage

// File: rtl/memory_store.sv
// Vector store serialiser: latches one LANES x LANE_W vector plus a base address and
// writes it to a lane-wide memory one lane per CLK_MEM strobe, then pulses HANDSHAKE.
module memory_store #(
    parameter int unsigned LANES     = mem_pkg::LANES,
    parameter int unsigned LANE_W    = mem_pkg::LANE_W,
    parameter int unsigned ADDR_STEP = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CLK_MEM,
    input  logic                    START,
    input  logic [31:0]             ADDRESS,
    input  logic [LANES*LANE_W-1:0] WRITE,
    output logic                    BUSY,
    output logic                    HANDSHAKE,
    output logic                    WE_MEM,
    output logic [31:0]             ADDRESS_MEM,
    output logic [LANE_W-1:0]       WRITE_MEM
);
    import mem_pkg::*;

    localparam int unsigned VEC_BITS   = LANES * LANE_W;
    localparam int unsigned LANE_CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(LANES - 1);

    store_state_e            state_q;
    logic [31:0]             base_q;
    logic [VEC_BITS-1:0]     data_q;
    logic [LANE_CNT_W-1:0]   lane_q;
    logic                    busy_q;
    logic                    hs_q;
    logic                    we_q;
    logic [31:0]             addr_q;
    logic [LANE_W-1:0]       wdata_q;

    logic [LANE_CNT_W-1:0]   lane_nx;
    logic [LANE_W-1:0]       nx_word;
    logic [31:0]             nx_addr;

    // Address and data of the lane that follows the one currently on the bus
    always_comb begin
        lane_nx = lane_q + LANE_CNT_W'(1);
        nx_word = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (lane_nx == LANE_CNT_W'(i)) begin
                nx_word = data_q[i*LANE_W +: LANE_W];
            end
        end
        nx_addr = lane_addr(base_q, 32'(lane_nx), 32'(ADDR_STEP));
    end

    // Store FSM; outputs are registered alongside the state so they follow it exactly
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            base_q  <= '0;
            data_q  <= '0;
            lane_q  <= '0;
            busy_q  <= 1'b0;
            hs_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (CLK_MEM) begin
            case (state_q)
                StIdle: begin
                    if (START) begin
                        state_q <= StWrite;
                        base_q  <= ADDRESS;
                        data_q  <= WRITE;
                        lane_q  <= '0;
                        busy_q  <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= ADDRESS;
                        wdata_q <= WRITE[LANE_W-1:0];
                    end
                end
                StWrite: begin
                    if (lane_q > LAST_LANE) begin
                        // Out-of-range lane counter: abandon rather than write garbage
                        state_q <= StIdle;
                        lane_q  <= '0;
                        busy_q  <= 1'b0;
                        we_q    <= 1'b0;
                        addr_q  <= base_q;
                        wdata_q <= data_q[LANE_W-1:0];
                    end else if (lane_q == LAST_LANE) begin
                        state_q <= StDone;
                        hs_q    <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= base_q;
                        wdata_q <= data_q[LANE_W-1:0];
                    end else begin
                        lane_q  <= lane_nx;
                        addr_q  <= nx_addr;
                        wdata_q <= nx_word;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    lane_q  <= '0;
                    busy_q  <= 1'b0;
                    hs_q    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    lane_q  <= '0;
                    busy_q  <= 1'b0;
                    hs_q    <= 1'b0;
                    we_q    <= 1'b0;
                    addr_q  <= base_q;
                    wdata_q <= data_q[LANE_W-1:0];
                end
            endcase
        end
    end

    assign BUSY        = busy_q;
    assign HANDSHAKE   = hs_q;
    assign WE_MEM      = we_q;
    assign ADDRESS_MEM = addr_q;
    assign WRITE_MEM   = wdata_q;

endmodule

// File: tb/tb_memory_store.sv
// Scoreboard bench for memory_store: stimulus pushes expected lane writes, a monitor
// pops them as the DUT presents writes and checks pulse widths and strobe gating.
module tb_memory_store;

    localparam int unsigned LANES = 3;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CLK_MEM = 1'b1;
    logic        START = 1'b0;
    logic [31:0] ADDRESS = '0;
    logic [47:0] WRITE = '0;
    logic        BUSY;
    logic        HANDSHAKE;
    logic        WE_MEM;
    logic [31:0] ADDRESS_MEM;
    logic [15:0] WRITE_MEM;

    memory_store dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CLK_MEM     (CLK_MEM),
        .START       (START),
        .ADDRESS     (ADDRESS),
        .WRITE       (WRITE),
        .BUSY        (BUSY),
        .HANDSHAKE   (HANDSHAKE),
        .WE_MEM      (WE_MEM),
        .ADDRESS_MEM (ADDRESS_MEM),
        .WRITE_MEM   (WRITE_MEM)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          hs_exp = 0;
    int          hs_pulses = 0;
    int          hs_len = 0;
    int          busy_len = 0;
    int unsigned div = 1;
    int unsigned phase = 0;
    logic        strobe_seen = 1'b0;
    logic [50:0] snap = '0;

    // Strobe generator: CLK_MEM high on one CLK in every div
    initial begin
        forever begin
            @(negedge CLK);
            phase = phase + 1;
            CLK_MEM = ((phase % div) == 0);
        end
    end

    always @(posedge CLK) strobe_seen <= CLK_MEM;

    // Monitor: pop a write per strobe with WE_MEM, check hold between strobes, pulse widths
    initial begin
        wr_t e;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                hs_len = 0;
                busy_len = 0;
            end else begin
                if (!strobe_seen) begin
                    checks++;
                    if ({WE_MEM, ADDRESS_MEM, WRITE_MEM, HANDSHAKE, BUSY} !== snap) begin
                        errors++;
                        $display("FAIL hold: got %h required %h", {WE_MEM, ADDRESS_MEM, WRITE_MEM,
                                 HANDSHAKE, BUSY}, snap);
                    end
                end else if (WE_MEM) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: got addr %h data %h, required no write",
                                 ADDRESS_MEM, WRITE_MEM);
                    end else begin
                        e = exp_q.pop_front();
                        if (ADDRESS_MEM !== e.addr || WRITE_MEM !== e.data) begin
                            errors++;
                            $display("FAIL write: got addr %h data %h required addr %h data %h",
                                     ADDRESS_MEM, WRITE_MEM, e.addr, e.data);
                        end
                    end
                end
                if (HANDSHAKE === 1'b1) begin
                    hs_len++;
                end else if (hs_len != 0) begin
                    checks++;
                    if (hs_len != int'(div)) begin
                        errors++;
                        $display("FAIL hs_width: got %0d CLKs required %0d", hs_len, div);
                    end
                    hs_pulses++;
                    hs_len = 0;
                end
                if (BUSY === 1'b1) begin
                    busy_len++;
                end else if (busy_len != 0) begin
                    checks++;
                    if (busy_len != int'((LANES + 1) * div)) begin
                        errors++;
                        $display("FAIL busy_width: got %0d CLKs required %0d", busy_len,
                                 (LANES + 1) * div);
                    end
                    busy_len = 0;
                end
            end
            snap = {WE_MEM, ADDRESS_MEM, WRITE_MEM, HANDSHAKE, BUSY};
        end
    end

    task automatic push(input logic [31:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check1(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    // Hold START until a strobe samples it (DUT assumed idle)
    task automatic issue(input logic [31:0] a, input logic [47:0] d);
        int n;
        @(negedge CLK);
        ADDRESS = a;
        WRITE = d;
        START = 1'b1;
        n = 0;
        do begin
            @(posedge CLK);
            n++;
        end while (!CLK_MEM && n < 100);
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Wait for the DUT to go idle and the scoreboard to empty, then reconcile counts
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((BUSY !== 1'b0 || exp_q.size() != 0 || hs_len != 0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_timeout: got busy %b pending %0d required idle and 0", name, BUSY,
                     exp_q.size());
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d writes outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (hs_pulses != hs_exp) begin
            errors++;
            $display("FAIL %s_handshakes: got %0d required %0d", name, hs_pulses, hs_exp);
            hs_pulses = hs_exp;
        end
    endtask

    initial begin
        int n;
        int gap;

        // Reset state
        repeat (2) @(negedge CLK);
        check1("rst_busy", BUSY, 1'b0);
        check1("rst_hs", HANDSHAKE, 1'b0);
        check1("rst_we", WE_MEM, 1'b0);
        checks++;
        if (ADDRESS_MEM !== 32'h0 || WRITE_MEM !== 16'h0) begin
            errors++;
            $display("FAIL rst_bus: got addr %h data %h required 0 0", ADDRESS_MEM, WRITE_MEM);
        end
        #2 RESET = 1'b0;

        // 1: basic
        push(32'h100, 16'h1111);
        push(32'h101, 16'h2222);
        push(32'h102, 16'h3333);
        hs_exp++;
        issue(32'h100, 48'h3333_2222_1111);
        drain("basic");

        // 2: strobe every 4th CLK
        div = 4;
        push(32'h100, 16'h1111);
        push(32'h101, 16'h2222);
        push(32'h102, 16'h3333);
        hs_exp++;
        issue(32'h100, 48'h3333_2222_1111);
        drain("gated");
        div = 1;
        repeat (4) @(negedge CLK);

        // 3: START while busy is ignored
        push(32'h100, 16'h1111);
        push(32'h101, 16'h2222);
        push(32'h102, 16'h3333);
        hs_exp++;
        issue(32'h100, 48'h3333_2222_1111);
        @(posedge CLK);
        @(negedge CLK);
        ADDRESS = 32'h200;
        WRITE = 48'hFFFF_FFFF_FFFF;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        drain("busy_ignore");

        // 4: address wrap
        push(32'hFFFF_FFFF, 16'h000A);
        push(32'h0000_0000, 16'h000B);
        push(32'h0000_0001, 16'h000C);
        hs_exp++;
        issue(32'hFFFF_FFFF, 48'h000C_000B_000A);
        drain("wrap");

        // 5: async reset during lane 1
        push(32'h300, 16'h0555);
        push(32'h301, 16'h0666);
        issue(32'h300, 48'h0777_0666_0555);
        @(posedge CLK);
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        check1("arst_we", WE_MEM, 1'b0);
        check1("arst_busy", BUSY, 1'b0);
        check1("arst_hs", HANDSHAKE, 1'b0);
        @(negedge CLK);
        #2 RESET = 1'b0;
        push(32'h300, 16'h0555);
        push(32'h301, 16'h0666);
        push(32'h302, 16'h0777);
        hs_exp++;
        issue(32'h300, 48'h0777_0666_0555);
        drain("after_reset");

        // 6: streaming with START held high
        push(32'h400, 16'h4441);
        push(32'h401, 16'h4442);
        push(32'h402, 16'h4443);
        push(32'h500, 16'h5551);
        push(32'h501, 16'h5552);
        push(32'h502, 16'h5553);
        hs_exp += 2;
        @(negedge CLK);
        ADDRESS = 32'h400;
        WRITE = 48'h4443_4442_4441;
        START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        ADDRESS = 32'h500;
        WRITE = 48'h5553_5552_5551;
        n = 0;
        while (BUSY !== 1'b0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        gap = 0;
        while (BUSY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            gap++;
            n++;
        end
        START = 1'b0;
        checks++;
        if (gap != 1) begin
            errors++;
            $display("FAIL stream_gap: got %0d idle CLKs required 1", gap);
        end
        drain("stream");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish before 200000");
        $fatal(1);
    end

endmodule
